// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake on both sides, a one-entry
// skid buffer and synchronous flush; in_ready/out_valid come straight from flops.
module pipe_skid_reg #(
    parameter int unsigned            WIDTH     = 32,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_xfer, out_xfer;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_xfer  = in_valid && in_ready_q;
        out_xfer = out_valid_q && out_ready;

        if (flush) begin
            // Entries are discarded, data registers keep their contents.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Handshake outputs are decoded from the next state and registered.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        case (state_d)
            BUSY:    occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed stimulus pushes expected outputs,
// a monitor pops them on each output transfer; a second 8-bit instance checks RESET_VAL.
module tb_pipe_skid_reg;

    logic        clk;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        r_reset, r_flush, r_in_valid, r_out_ready;
    logic        r_in_ready, r_out_valid;
    logic [7:0]  r_in_data, r_out_data;
    logic [1:0]  r_occupancy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h03)) dut8 (
        .clk(clk), .reset(r_reset), .flush(r_flush),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .occupancy(r_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; acc marks a hand-computed expected input transfer.
    task automatic cyc(input logic v, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        if (acc) exp_q.push_back(d);
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc8(input logic v, input logic [7:0] d, input logic rst);
        r_in_valid = v;
        r_in_data  = d;
        r_reset    = rst;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_xfer: got=%h expected=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_xfer: got=%h expected=%h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        r_reset = 1'b1; r_flush = 1'b0; r_in_valid = 1'b0; r_in_data = 8'h0; r_out_ready = 1'b0;

        // Reset held two cycles while upstream offers data
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        r_reset = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_occ", {30'b0, occupancy}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst8_out_data", {24'b0, r_out_data}, 32'h03);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("idle_occ", {30'b0, occupancy}, 32'd0);

        // Streaming with downstream always ready
        cyc(1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
        chk("str_data0", out_data, 32'h11);
        cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
        chk("str_data1", out_data, 32'h22);
        chk("str_occ1", {30'b0, occupancy}, 32'd1);
        cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b1);
        chk("str_data2", out_data, 32'h33);
        chk("str_rdy2", {31'b0, in_ready}, 32'd1);
        cyc(1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
        chk("str_data3", out_data, 32'h44);
        chk("str_occ3", {30'b0, occupancy}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("str_drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure fills skid, third offer refused until space returns
        cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1);
        chk("bp_occ1", {30'b0, occupancy}, 32'd1);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1);
        chk("bp_occ2", {30'b0, occupancy}, 32'd2);
        chk("bp_rdy_low", {31'b0, in_ready}, 32'd0);
        cyc(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_occ", {30'b0, occupancy}, 32'd2);
        chk("bp_hold_data", out_data, 32'hA1);
        cyc(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
        chk("bp_skid_move", out_data, 32'hA2);
        chk("bp_occ_back", {30'b0, occupancy}, 32'd1);
        cyc(1'b1, 32'hA3, 1'b1, 1'b0, 1'b1);
        chk("bp_a3", out_data, 32'hA3);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp_empty", {30'b0, occupancy}, 32'd0);

        // Simultaneous in/out in BUSY bypasses skid
        cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h6, 1'b1, 1'b0, 1'b1);
        chk("sim_data", out_data, 32'h6);
        chk("sim_occ", {30'b0, occupancy}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL discards entries and the offered input
        cyc(1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
        chk("fl_full", {30'b0, occupancy}, 32'd2);
        cyc(1'b1, 32'h9, 1'b1, 1'b1, 1'b0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_occ", {30'b0, occupancy}, 32'd0);
        chk("fl_rdy", {31'b0, in_ready}, 32'd1);
        chk("fl_keep_data", out_data, 32'h7);
        cyc(1'b1, 32'hB, 1'b1, 1'b0, 1'b1);
        chk("fl_next", out_data, 32'hB);
        chk("fl_next_valid", {31'b0, out_valid}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
        end

        // Reset mid-operation on the 8-bit instance with RESET_VAL=3
        cyc8(1'b1, 8'h07, 1'b0);
        cyc8(1'b1, 8'h08, 1'b0);
        chk("r8_full_occ", {30'b0, r_occupancy}, 32'd2);
        chk("r8_full_rdy", {31'b0, r_in_ready}, 32'd0);
        cyc8(1'b1, 8'h09, 1'b1);
        chk("r8_rst_valid", {31'b0, r_out_valid}, 32'd0);
        chk("r8_rst_occ", {30'b0, r_occupancy}, 32'd0);
        chk("r8_rst_data", {24'b0, r_out_data}, 32'h03);
        chk("r8_rst_rdy", {31'b0, r_in_ready}, 32'd1);
        cyc8(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
